flopd_pipe: RTL and testbench

Parametrised elastic register pipeline: WIDTH-bit data passes through DEPTH register stages with a valid/ready handshake on both sides, so back-pressure stalls the pipe without losing or duplicating beats. Successor to the fixed 8-bit D register used between datapath blocks. Sits between any producer/consumer pair in the processor datapath that needs a registered boundary with flow control and a synchronous flush.

---
 rtl/flopd_pipe_if.sv | 41 ++++
 rtl/flopd_pipe.sv | 117 +++++++++++
 tb/tb_flopd_pipe.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flopd_pipe_if.sv
// flopd_pipe_if
//   Handshake bundle for the flopd_pipe elastic register pipeline. It holds
//   both sides of the pipe: the upstream beat (input_d / input_valid /
//   input_ready) and the downstream beat (output_q / output_valid /
//   output_ready).
//
//   Parameter:
//     WIDTH  data width in bits; must match the WIDTH of the attached pipe
//
//   Modports:
//     slave   the pipe itself: takes upstream data/valid and downstream
//             ready, drives input_ready, output_q and output_valid
//     master  the surrounding producer/consumer pair: the mirror image
interface flopd_pipe_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] input_d;
  logic             input_valid;
  logic             input_ready;
  logic [WIDTH-1:0] output_q;
  logic             output_valid;
  logic             output_ready;

  modport master (
    output input_d,
    output input_valid,
    input  input_ready,
    input  output_q,
    input  output_valid,
    output output_ready
  );

  modport slave (
    input  input_d,
    input  input_valid,
    output input_ready,
    output output_q,
    output output_valid,
    input  output_ready
  );
endinterface

// File: rtl/flopd_pipe.sv
// flopd_pipe
//   Parametrised elastic register pipeline. WIDTH-bit beats pass through
//   DEPTH register stages with valid/ready flow control on both sides, so
//   back-pressure stalls the pipe without losing or duplicating beats.
//   Empty stages ahead of a stalled stage keep loading, so bubbles collapse
//   and the pipe holds up to DEPTH beats. A synchronous flush empties every
//   stage.
//
//   Parameters:
//     WIDTH  data width in bits (>= 1)
//     DEPTH  number of register stages (>= 1)
//
//   Ports:
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset; clears valids and data
//     flush      synchronous clear of all stage valids (data regs hold)
//     bus        flopd_pipe_if slave: input_d/input_valid/input_ready
//                upstream, output_q/output_valid/output_ready downstream
//     occupancy  beats currently held (only with FLOPD_PIPE_OCCUPANCY_EN)
//
//   Configuration macro:
//     FLOPD_PIPE_OCCUPANCY_EN  when defined, adds the occupancy port and a
//                              registered beat counter
module flopd_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  flopd_pipe_if.slave bus
`ifdef FLOPD_PIPE_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

  logic [DEPTH-1:0]            v;
  logic [DEPTH-1:0][WIDTH-1:0] d;
  logic [DEPTH-1:0]            r;
  logic [DEPTH-1:0]            v_in;
  logic [DEPTH-1:0][WIDTH-1:0] d_in;

  // Ready ripples backwards from the consumer: a stage can load when it is
  // empty or when the stage after it is able to take its beat this cycle.
  always_comb begin
    r          = '0;
    r[DEPTH-1] = ~v[DEPTH-1] | bus.output_ready;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      r[k] = ~v[k] | r[k+1];
    end
  end

  // Reset and flush block the upstream side so no beat slips in while the
  // pipe is being cleared.
  assign bus.input_ready  = r[0] & ~flush & rst_n;
  assign bus.output_valid = v[DEPTH-1] & ~flush;
  assign bus.output_q     = d[DEPTH-1];

  // What each stage would capture: the accepted input beat for stage 0,
  // the previous stage's contents for the rest.
  always_comb begin
    v_in    = '0;
    d_in    = '0;
    v_in[0] = bus.input_valid & bus.input_ready;
    d_in[0] = bus.input_d;
    for (int k = 1; k < DEPTH; k++) begin
      v_in[k] = v[k-1];
      d_in[k] = d[k-1];
    end
  end

  // Data only moves with a valid beat, so stage data holds across bubbles
  // and flushes and output_q never changes without a reason.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      d <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (r[k]) begin
          v[k] <= v_in[k];
          if (v_in[k]) begin
            d[k] <= d_in[k];
          end
        end
      end
    end
  end

`ifdef FLOPD_PIPE_OCCUPANCY_EN
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = bus.input_valid & bus.input_ready;
  assign out_xfer = bus.output_valid & bus.output_ready;

  // Accept and emit on the same cycle cancel out; flush forces both
  // transfers low, so clearing to zero matches the emptied stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (in_xfer && !out_xfer) begin
      occupancy <= occupancy + OCC_W'(1);
    end else if (out_xfer && !in_xfer) begin
      occupancy <= occupancy - OCC_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_flopd_pipe.sv
// tb_flopd_pipe
//   Self-checking bench for flopd_pipe. Three instances share clk/rst_n:
//     inst 0: WIDTH 8, DEPTH 2 (reset, streaming, back-pressure)
//     inst 1: WIDTH 8, DEPTH 4 (random stall, flush, mid-stream reset)
//     inst 2: WIDTH 8, DEPTH 1 (random stall)
//   Inputs change 1 ns after each rising edge; outputs are sampled 1 ns
//   later, so every sampled valid/ready pair is the one the next edge acts
//   on. Accepted beats go into a per-instance queue and are popped and
//   compared when the pipe emits.
`timescale 1ns/1ps
module tb_flopd_pipe;

  localparam int NI = 3;

  logic clk;
  logic rst_n;

  logic       flush     [NI];
  logic [7:0] in_d      [NI];
  logic       in_valid  [NI];
  logic       in_ready  [NI];
  logic [7:0] out_q     [NI];
  logic       out_valid [NI];
  logic       out_ready [NI];

  logic       drv_rst_n;
  logic       drv_flush [NI];
  logic [7:0] drv_d     [NI];
  logic       drv_valid [NI];
  logic       drv_ready [NI];

  flopd_pipe_if #(.WIDTH(8)) if0 ();
  flopd_pipe_if #(.WIDTH(8)) if1 ();
  flopd_pipe_if #(.WIDTH(8)) if2 ();

  assign if0.input_d      = in_d[0];
  assign if0.input_valid  = in_valid[0];
  assign if0.output_ready = out_ready[0];
  assign in_ready[0]      = if0.input_ready;
  assign out_q[0]         = if0.output_q;
  assign out_valid[0]     = if0.output_valid;

  assign if1.input_d      = in_d[1];
  assign if1.input_valid  = in_valid[1];
  assign if1.output_ready = out_ready[1];
  assign in_ready[1]      = if1.input_ready;
  assign out_q[1]         = if1.output_q;
  assign out_valid[1]     = if1.output_valid;

  assign if2.input_d      = in_d[2];
  assign if2.input_valid  = in_valid[2];
  assign if2.output_ready = out_ready[2];
  assign in_ready[2]      = if2.input_ready;
  assign out_q[2]         = if2.output_q;
  assign out_valid[2]     = if2.output_valid;

`ifdef FLOPD_PIPE_OCCUPANCY_EN
  logic [1:0] occ0;
  logic [2:0] occ1;
  logic [0:0] occ2;
  int         occ [NI];
  assign occ[0] = int'(occ0);
  assign occ[1] = int'(occ1);
  assign occ[2] = int'(occ2);

  flopd_pipe #(.WIDTH(8), .DEPTH(2)) dut0 (.clk(clk), .rst_n(rst_n), .flush(flush[0]), .bus(if0.slave), .occupancy(occ0));
  flopd_pipe #(.WIDTH(8), .DEPTH(4)) dut1 (.clk(clk), .rst_n(rst_n), .flush(flush[1]), .bus(if1.slave), .occupancy(occ1));
  flopd_pipe #(.WIDTH(8), .DEPTH(1)) dut2 (.clk(clk), .rst_n(rst_n), .flush(flush[2]), .bus(if2.slave), .occupancy(occ2));
`else
  flopd_pipe #(.WIDTH(8), .DEPTH(2)) dut0 (.clk(clk), .rst_n(rst_n), .flush(flush[0]), .bus(if0.slave));
  flopd_pipe #(.WIDTH(8), .DEPTH(4)) dut1 (.clk(clk), .rst_n(rst_n), .flush(flush[1]), .bus(if1.slave));
  flopd_pipe #(.WIDTH(8), .DEPTH(1)) dut2 (.clk(clk), .rst_n(rst_n), .flush(flush[2]), .bus(if2.slave));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run;
  int tests_failed;
  int cyc;

  logic [7:0] sb0 [$];
  logic [7:0] sb1 [$];
  logic [7:0] sb2 [$];

  logic acc        [NI];
  int   emit_count [NI];
  int   first_push [NI];
  int   first_pop  [NI];
  int   last_pop   [NI];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic applyStimulus();
    rst_n = drv_rst_n;
    for (int i = 0; i < NI; i++) begin
      flush[i]     = drv_flush[i];
      in_d[i]      = drv_d[i];
      in_valid[i]  = drv_valid[i];
      out_ready[i] = drv_ready[i];
    end
  endtask

  function automatic int sbSize(input int i);
    case (i)
      0:       return sb0.size();
      1:       return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  task automatic sbPush(input int i, input logic [7:0] val);
    case (i)
      0:       sb0.push_back(val);
      1:       sb1.push_back(val);
      default: sb2.push_back(val);
    endcase
  endtask

  task automatic sbPop(input int i, output logic [7:0] val);
    case (i)
      0:       val = sb0.pop_front();
      1:       val = sb1.pop_front();
      default: val = sb2.pop_front();
    endcase
  endtask

  task automatic sbClear(input int i);
    case (i)
      0:       sb0.delete();
      1:       sb1.delete();
      default: sb2.delete();
    endcase
  endtask

  task automatic clearStats();
    for (int i = 0; i < NI; i++) begin
      emit_count[i] = 0;
      first_push[i] = -1;
      first_pop[i]  = -1;
      last_pop[i]   = -1;
    end
  endtask

  // One clock: drive after the edge, sample before the next, then score
  // the transfers that the next edge will perform.
  task automatic runCycle();
    logic [7:0] exp_q;
    @(posedge clk);
    cyc++;
    #1;
    applyStimulus();
    #1;
    for (int i = 0; i < NI; i++) begin
      acc[i] = 1'b0;
      if (!rst_n) begin
        checkOutput($sformatf("rst_out_valid[%0d]", i), 32'(out_valid[i]), 32'd0);
        checkOutput($sformatf("rst_out_q[%0d]", i), 32'(out_q[i]), 32'd0);
        checkOutput($sformatf("rst_in_ready[%0d]", i), 32'(in_ready[i]), 32'd0);
        sbClear(i);
      end else begin
`ifdef FLOPD_PIPE_OCCUPANCY_EN
        checkOutput($sformatf("occupancy[%0d]", i), 32'(occ[i]), 32'(sbSize(i)));
`endif
        if (sbSize(i) == 0 && out_valid[i]) begin
          checkOutput($sformatf("spurious_valid[%0d]", i), 32'(out_valid[i]), 32'd0);
        end
        if (drv_flush[i]) begin
          checkOutput($sformatf("flush_out_valid[%0d]", i), 32'(out_valid[i]), 32'd0);
          checkOutput($sformatf("flush_in_ready[%0d]", i), 32'(in_ready[i]), 32'd0);
          sbClear(i);
        end else begin
          if (out_valid[i] && out_ready[i] && sbSize(i) > 0) begin
            sbPop(i, exp_q);
            checkOutput($sformatf("data[%0d]", i), 32'(out_q[i]), 32'(exp_q));
            emit_count[i]++;
            if (first_pop[i] < 0) first_pop[i] = cyc;
            last_pop[i] = cyc;
          end
          if (in_valid[i] && in_ready[i]) begin
            sbPush(i, in_d[i]);
            acc[i] = 1'b1;
            if (first_push[i] < 0) first_push[i] = cyc;
          end
        end
      end
    end
  endtask

  task automatic drainPipe(input int i, input int max_cycles);
    drv_valid[i] = 1'b0;
    drv_ready[i] = 1'b1;
    for (int c = 0; c < max_cycles && sbSize(i) > 0; c++) begin
      runCycle();
    end
    checkOutput($sformatf("drained[%0d]", i), 32'(sbSize(i)), 32'd0);
  endtask

  int cnt;
  int sent [NI];
  bit done;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    drv_rst_n    = 1'b0;
    for (int i = 0; i < NI; i++) begin
      drv_flush[i] = 1'b0;
      drv_d[i]     = 8'hA5;
      drv_valid[i] = 1'b1;
      drv_ready[i] = 1'b0;
    end
    applyStimulus();
    clearStats();

    // Reset held three cycles with a beat offered upstream.
    for (int c = 0; c < 3; c++) runCycle();
    for (int i = 0; i < NI; i++) drv_valid[i] = 1'b0;
    drv_rst_n = 1'b1;
    runCycle();
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("post_rst_in_ready[%0d]", i), 32'(in_ready[i]), 32'd1);
    end

    // Streaming 01..10 through DEPTH 2 with output_ready held high.
    clearStats();
    drv_ready[0] = 1'b1;
    for (int val = 1; val <= 16; val++) begin
      drv_valid[0] = 1'b1;
      drv_d[0]     = 8'(val);
      runCycle();
      checkOutput("stream_in_ready", 32'(in_ready[0]), 32'd1);
    end
    drainPipe(0, 10);
    checkOutput("stream_count", 32'(emit_count[0]), 32'd16);
    checkOutput("stream_latency", 32'(first_pop[0] - first_push[0]), 32'd2);
    checkOutput("stream_rate", 32'(last_pop[0] - first_pop[0]), 32'd15);

    // Back-pressure: only two of 11/22/33 fit while output_ready is low.
    clearStats();
    drv_ready[0] = 1'b0;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      drv_valid[0] = 1'b1;
      drv_d[0]     = (cnt == 0) ? 8'h11 : (cnt == 1) ? 8'h22 : 8'h33;
      runCycle();
      if (acc[0]) cnt++;
    end
    checkOutput("bp_accepts", 32'(cnt), 32'd2);
    checkOutput("bp_in_ready", 32'(in_ready[0]), 32'd0);
    drv_ready[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      drv_valid[0] = (cnt < 3);
      drv_d[0]     = (cnt == 0) ? 8'h11 : (cnt == 1) ? 8'h22 : 8'h33;
      runCycle();
      if (acc[0]) cnt++;
    end
    drainPipe(0, 10);
    checkOutput("bp_total_accepts", 32'(cnt), 32'd3);
    checkOutput("bp_emits", 32'(emit_count[0]), 32'd3);

    // Random valid/ready on DEPTH 4 and DEPTH 1, 1000 beats each.
    clearStats();
    sent[1] = 0;
    sent[2] = 0;
    done    = 1'b0;
    for (int c = 0; c < 10000 && !done; c++) begin
      for (int i = 1; i < NI; i++) begin
        drv_valid[i] = (sent[i] < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
        drv_d[i]     = 8'($urandom);
        drv_ready[i] = 1'($urandom_range(0, 1));
      end
      runCycle();
      for (int i = 1; i < NI; i++) begin
        if (acc[i]) sent[i]++;
      end
      done = (sent[1] == 1000) && (sent[2] == 1000);
    end
    drainPipe(1, 20);
    drainPipe(2, 20);
    checkOutput("rand_emits[1]", 32'(emit_count[1]), 32'd1000);
    checkOutput("rand_emits[2]", 32'(emit_count[2]), 32'd1000);

    // Flush a full DEPTH 4 pipe while a beat is offered.
    clearStats();
    drv_ready[1] = 1'b0;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      drv_valid[1] = (cnt < 4);
      drv_d[1]     = 8'(8'h40 + cnt);
      runCycle();
      if (acc[1]) cnt++;
    end
    checkOutput("flush_fill", 32'(cnt), 32'd4);
    checkOutput("full_in_ready", 32'(in_ready[1]), 32'd0);
    checkOutput("full_out_valid", 32'(out_valid[1]), 32'd1);
    drv_flush[1] = 1'b1;
    drv_valid[1] = 1'b1;
    drv_d[1]     = 8'h77;
    runCycle();
    drv_flush[1] = 1'b0;
    drv_valid[1] = 1'b0;
    runCycle();
    checkOutput("flush_empty", 32'(out_valid[1]), 32'd0);
    drv_ready[1] = 1'b1;
    for (int c = 0; c < 6; c++) runCycle();
    checkOutput("flush_no_emit", 32'(emit_count[1]), 32'd0);
    drv_valid[1] = 1'b1;
    drv_d[1]     = 8'h99;
    runCycle();
    drainPipe(1, 10);
    checkOutput("post_flush_emit", 32'(emit_count[1]), 32'd1);

    // Asynchronous reset between edges with three beats held.
    clearStats();
    drv_ready[1] = 1'b0;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      drv_valid[1] = (cnt < 3);
      drv_d[1]     = 8'(8'hC1 + cnt);
      runCycle();
      if (acc[1]) cnt++;
    end
    checkOutput("mid_fill", 32'(cnt), 32'd3);
    checkOutput("mid_out_valid", 32'(out_valid[1]), 32'd1);
    drv_rst_n = 1'b0;
    runCycle();
    drv_rst_n    = 1'b1;
    drv_ready[1] = 1'b1;
    runCycle();
    checkOutput("mid_in_ready", 32'(in_ready[1]), 32'd1);
    for (int c = 0; c < 8; c++) runCycle();
    checkOutput("mid_no_emit", 32'(emit_count[1]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
